// File: rtl/waterfall_ctrl_pkg.sv
// Shared types and constants for the LED waterfall controller.
// next_pattern() holds the per-mode LED stepping rules used by the top FSM.
package waterfall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'b00,
        MODE_RIGHT  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    localparam int unsigned MUL_X1  = 1;
    localparam int unsigned MUL_X2  = 2;
    localparam int unsigned MUL_X5  = 5;
    localparam int unsigned MUL_X10 = 10;

    localparam logic [7:0] LED_RST = 8'h01;

    // Returns {dir_right_next, led_next}. Bounce turns around at either
    // endpoint regardless of the stored direction, so entry from 8'h80 works.
    function automatic logic [8:0] next_pattern(input mode_t m, input logic [7:0] led,
                                                input logic dir_right);
        logic       go_left;
        logic [7:0] nxt;
        logic       dr;
        go_left = (led == 8'h01) || (!dir_right && (led != 8'h80));
        nxt     = led;
        dr      = dir_right;
        case (m)
            MODE_LEFT:   nxt = (led == 8'h80) ? 8'h01 : {led[6:0], 1'b0};
            MODE_RIGHT:  nxt = (led == 8'h01) ? 8'h80 : {1'b0, led[7:1]};
            MODE_BOUNCE: begin
                nxt = go_left ? {led[6:0], 1'b0} : {1'b0, led[7:1]};
                dr  = go_left ? (nxt == 8'h80) : (nxt != 8'h01);
            end
            default:     nxt = (led == 8'hFF) ? 8'h01 : {led[6:0], 1'b1};
        endcase
        return {dr, nxt};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button debouncer: the filtered level follows the input only after
// DB_CYCLES consecutive samples differ from it; rise pulses on its 0->1 change.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic [15:0] run_cnt;
    logic        level;
    logic        level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            level_q <= level;
            if (btn == level) begin
                run_cnt <= '0;
            end else if (run_cnt == 16'(DB_CYCLES - 1)) begin
                level   <= btn;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 16'd1;
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/waterfall_ctrl.sv
// LED waterfall controller: IDLE/RUN/PAUSE FSM stepping an 8-bit pattern.
// Define WATERFALL_CTRL_DEBOUNCE_EN to pass the buttons through btn_debounce.
module waterfall_ctrl
    import waterfall_ctrl_pkg::*;
#(
    parameter int unsigned TICK_UNIT = 10_000_000,
    parameter int unsigned DB_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       pause_btn,
    input  logic [1:0] freq_set,
    input  logic [1:0] mode,
    output logic [7:0] led,
    output logic       busy,
    output logic       tick
);

    if (TICK_UNIT < 1 || TICK_UNIT > 400_000_000) begin : g_bad_tick_unit
        $error("waterfall_ctrl: TICK_UNIT out of range");
    end
    if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_bad_db_cycles
        $error("waterfall_ctrl: DB_CYCLES out of range");
    end

    // 10 * 400M still fits in 32 bits; products are formed in 64 bits first.
    localparam logic [63:0] TU64    = 64'(TICK_UNIT);
    localparam logic [31:0] LIM_X1  = 32'(TU64 * 64'(MUL_X1));
    localparam logic [31:0] LIM_X2  = 32'(TU64 * 64'(MUL_X2));
    localparam logic [31:0] LIM_X5  = 32'(TU64 * 64'(MUL_X5));
    localparam logic [31:0] LIM_X10 = 32'(TU64 * 64'(MUL_X10));

    logic start_rise, stop_rise, pause_rise;

`ifdef WATERFALL_CTRL_DEBOUNCE_EN
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk(clk), .rst(rst), .btn(start_btn), .rise(start_rise)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
        .clk(clk), .rst(rst), .btn(stop_btn), .rise(stop_rise)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk(clk), .rst(rst), .btn(pause_btn), .rise(pause_rise)
    );
`else
    logic [2:0] btn_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) btn_prev <= '0;
        else     btn_prev <= {pause_btn, stop_btn, start_btn};
    end

    assign start_rise = start_btn & ~btn_prev[0];
    assign stop_rise  = stop_btn  & ~btn_prev[1];
    assign pause_rise = pause_btn & ~btn_prev[2];
`endif

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [31:0] limit;
    logic [7:0]  led_n;
    logic        dir_right, dir_n;
    logic [1:0]  lat_freq, freq_n;
    mode_t       lat_mode, mode_n;
    logic        tick_n;
    logic [8:0]  step;
    logic        boundary;

    always_comb begin
        limit = LIM_X1;
        case (lat_freq)
            2'b01:   limit = LIM_X2;
            2'b10:   limit = LIM_X5;
            2'b11:   limit = LIM_X10;
            default: limit = LIM_X1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 32'd1;
            led       <= LED_RST;
            dir_right <= 1'b0;
            lat_freq  <= 2'b00;
            lat_mode  <= MODE_LEFT;
            tick      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            led       <= led_n;
            dir_right <= dir_n;
            lat_freq  <= freq_n;
            lat_mode  <= mode_n;
            tick      <= tick_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        led_n    = led;
        dir_n    = dir_right;
        freq_n   = lat_freq;
        mode_n   = lat_mode;
        tick_n   = 1'b0;
        step     = next_pattern(lat_mode, led, dir_right);
        boundary = (lat_mode == MODE_RIGHT) ? (step[7:0] == 8'h80) : (step[7:0] == LED_RST);

        if (stop_rise) begin
            state_n = ST_IDLE;
            cnt_n   = 32'd1;
            led_n   = LED_RST;
            dir_n   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start_rise) begin
                    state_n = ST_RUN;
                    cnt_n   = 32'd1;
                    freq_n  = freq_set;
                    mode_n  = mode_t'(mode);
                end
                ST_RUN: begin
                    if (pause_rise) begin
                        state_n = ST_PAUSE;
                    end else if (cnt == limit) begin
                        cnt_n  = 32'd1;
                        led_n  = step[7:0];
                        dir_n  = step[8];
                        tick_n = 1'b1;
                        // New speed/mode only take effect at a pattern boundary.
                        if (boundary) begin
                            freq_n = freq_set;
                            mode_n = mode_t'(mode);
                            if (mode_t'(mode) != lat_mode) dir_n = 1'b0;
                        end
                    end else begin
                        cnt_n = cnt + 32'd1;
                    end
                end
                ST_PAUSE: if (start_rise) state_n = ST_RUN;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: doc/waterfall_ctrl.md
WATERFALL_CTRL -- requirements
Module: waterfall_ctrl

Interface
REQ-001 Parameter TICK_UNIT, default 10_000_000, clk cycles per speed unit; legal range 1..400_000_000.
REQ-002 Parameter DB_CYCLES, default 20, consecutive stable samples a button needs when debounce is compiled in; legal range 2..65535.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset: asynchronous, active-high.
REQ-005 start_btn  input  1  start/resume request; level, clk-synchronous.
REQ-006 stop_btn  input  1  stop request; level, clk-synchronous.
REQ-007 pause_btn  input  1  pause request; level, clk-synchronous.
REQ-008 freq_set  input  2  speed select: 00=1, 01=2, 10=5, 11=10 units per step.
REQ-009 mode  input  2  pattern: 00 shift-left, 01 shift-right, 10 bounce, 11 fill.
REQ-010 led  output  8  LED pattern, registered.
REQ-011 busy  output  1  high in RUN or PAUSE.
REQ-012 tick  output  1  one-cycle pulse on each pattern step.

Function
REQ-013 FSM states are IDLE, RUN and PAUSE.
REQ-014 Commands are rising edges of the (debounced) button levels; priority is stop > pause > start.
REQ-015 Stop in any state: go to IDLE next edge; led=8'h01, cnt=1, direction=left.
REQ-016 Start in IDLE: latch freq_set/mode, cnt=1, go to RUN.
REQ-017 Start in PAUSE: return to RUN with cnt and led unchanged.
REQ-018 Start in RUN has no effect.
REQ-019 Pause in RUN: go to PAUSE; cnt and led hold; pause in IDLE or PAUSE has no effect.
REQ-020 limit = multiplier*TICK_UNIT, 32-bit unsigned; multipliers 1/2/5/10 come from the latched freq_set.
REQ-021 In RUN, cnt counts 1..limit; when cnt==limit: cnt<=1, led advances, tick=1 for that cycle; otherwise cnt<=cnt+1 and led holds.
REQ-022 The first step occurs exactly limit cycles after the RUN-entry edge.
REQ-023 Shift-left: led<<1, with 8'h80 wrapping to 8'h01.
REQ-024 Shift-right: led>>1, with 8'h01 wrapping to 8'h80.
REQ-025 Bounce: shift left up to 8'h80, then right down to 8'h01, then left again; each endpoint is shown once.
REQ-026 Fill: led<=(led<<1)|1; 8'hFF steps to 8'h01.
REQ-027 Pattern boundary = a step whose new led equals 8'h01 (for shift-right: the step whose new led equals 8'h80); at a boundary, freq_set/mode are re-latched and apply from the next step.
REQ-028 A mode change applied at a boundary restarts from the new led value, with direction=left.
REQ-029 tick is never asserted in IDLE or PAUSE.

Reset
REQ-030 rst asserted: state=IDLE, led=8'h01, busy=0, tick=0, cnt=1, direction=left, latched freq_set/mode=00, debounce/edge registers cleared.
REQ-031 rst asserted mid-RUN aborts immediately, with no tick.
REQ-032 After rst deasserts, the block waits in IDLE for a start edge.

Configuration
REQ-033 Macro WATERFALL_CTRL_DEBOUNCE_EN defined: each button passes a debouncer; its output level changes only after DB_CYCLES consecutive equal samples, so a command takes effect DB_CYCLES+1 cycles after the input settles.
REQ-034 Macro WATERFALL_CTRL_DEBOUNCE_EN undefined: the raw level is edge-detected against a registered previous sample; a command acts on the first cycle the input is high after a low.

Structure
REQ-035 Package waterfall_ctrl_pkg holds the state enum, mode enum, speed-multiplier constants (1,2,5,10) and the LED reset value 8'h01.
REQ-036 Sub-module btn_debounce holds one debouncer with edge output, instantiated three times when WATERFALL_CTRL_DEBOUNCE_EN is defined.

Verification (TICK_UNIT=2, debounce off unless stated)
REQ-037 freq_set=00, mode=00, start pulse -> led 01,02,04,...,80,01 every 2 cycles, tick with each step, busy=1.
REQ-038 mode=10, freq_set=01 -> led 01..80 then 40..01, one step every 4 cycles, no repeated endpoint.
REQ-039 Pause after 3 steps (led=08), hold 50 cycles, start -> led stays 08 with no tick; stepping resumes with the remaining count.
REQ-040 start, pause and stop pulses in the same cycle while in RUN -> IDLE, led=01, busy=0.
REQ-041 Change freq_set 00->11 and mode 00->11 mid-pattern -> the old pattern continues to 01, then fill 01,03,07,...,FF at 20-cycle steps.
REQ-042 Debounce on, DB_CYCLES=4, start glitch of 3 cycles -> ignored; glitch of 5 cycles -> RUN entered 5 cycles after the rise.
